// File: rtl/conv_pkg.sv
// conv_pkg: types and geometry helpers for the convolution-layer datapath.
// The scheduler and the IFM/weight address generators both import this package.
package conv_pkg;

  // Tile scheduler states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    FETCH   = 3'd2,
    COMPUTE = 3'd3,
    WRITE   = 3'd4,
    NEXT    = 3'd5,
    FIN     = 3'd6
  } sched_state_e;

  // Output feature map edge for a valid (already padded) convolution
  function automatic int ofm_size(input int ifm_edge, input int kernel_edge);
    return ifm_edge - kernel_edge + 1;
  endfunction

  // One tile covers tile_width columns of one OFM row
  function automatic int num_tiles(input int ofm_edge, input int tile_width);
    return ofm_edge * (ofm_edge / tile_width);
  endfunction

  // Width of a tile counter; never narrower than one bit
  function automatic int tile_idx_w(input int n_tiles);
    return (n_tiles > 1) ? $clog2(n_tiles) : 1;
  endfunction

endpackage

// File: rtl/sched_fall_detect.sv
// sched_fall_detect: registered falling-edge detector. The previous level of
// the watched strobe is held in a flop; fall_o is high in the first cycle the
// strobe is seen low after having been high.
module sched_fall_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic fall_o
);

  logic sig_q;

  // Remember last cycle's level of the watched strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign fall_o = sig_q & ~sig_i;

endmodule

// File: rtl/conv_tile_scheduler.sv
// conv_tile_scheduler: per-layer tile sequencer for the 16-filter systolic array.
// For each OFM tile: pulse the address-generator loads, wait for the IFM fetch
// to drain (falling edge of ifm_addr_valid), wait for the array result, then
// kick OFM write-back. After the last tile a one-cycle done is issued.
// Optional feature: define TILE_SCHED_PERF_EN to add the cycle_count output,
// a saturating count of busy cycles of the most recent layer.
module conv_tile_scheduler
  import conv_pkg::*;
#(
  parameter  int KERNEL_SIZE = 3,
  parameter  int IFM_SIZE    = 34,
  parameter  int IFM_CHANNEL = 3,
  parameter  int TILE_WIDTH  = 16,
  localparam int OFM_SIZE    = ofm_size(IFM_SIZE, KERNEL_SIZE),
  localparam int NUM_TILES   = num_tiles(OFM_SIZE, TILE_WIDTH),
  localparam int TILE_IDX_W  = tile_idx_w(NUM_TILES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic                  ifm_load,
  output logic                  wgt_load,
  input  logic                  ifm_addr_valid,
  input  logic                  pe_done,
  output logic                  ofm_wr_start,
  input  logic                  ofm_wr_done,
  output logic [TILE_IDX_W-1:0] tile_idx,
  output logic                  busy,
  output logic                  done
`ifdef TILE_SCHED_PERF_EN
  ,
  output logic [31:0]           cycle_count
`endif
);

  // Reject geometries the tiling scheme cannot express
  if ((IFM_CHANNEL < 1) || (TILE_WIDTH < 1) || (OFM_SIZE < 1) ||
      ((OFM_SIZE % TILE_WIDTH) != 0)) begin : g_bad_cfg
    $error("conv_tile_scheduler: unsupported layer geometry");
  end

  localparam logic [TILE_IDX_W-1:0] LAST_TILE = TILE_IDX_W'(NUM_TILES - 1);

  sched_state_e          state_q, state_d;
  logic [TILE_IDX_W-1:0] tile_q, tile_d;
  logic                  pe_sticky_q, pe_sticky_d;
  logic                  load_q, wr_start_q, busy_q, done_q;
  logic                  fetch_fall_s;
  logic                  start_acc_s;

  sched_fall_detect u_fall_detect (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (ifm_addr_valid),
    .fall_o (fetch_fall_s)
  );

  // A start only counts when idle and not cancelled by a simultaneous abort
  assign start_acc_s = (state_q == IDLE) && start && !abort;

  // Next-state, tile counter and pe_done sticky flag
  always_comb begin
    state_d     = state_q;
    tile_d      = tile_q;
    pe_sticky_d = pe_sticky_q;
    if ((state_q != IDLE) && abort) begin
      state_d     = IDLE;
      tile_d      = '0;
      pe_sticky_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tile_d      = '0;
          pe_sticky_d = 1'b0;
          if (start_acc_s) begin
            state_d = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
        LOAD: begin
          pe_sticky_d = 1'b0;
          state_d     = FETCH;
        end
        FETCH: begin
          // The array may finish before the fetch strobe drops; keep that event
          if (pe_done) begin
            pe_sticky_d = 1'b1;
          end else begin
            pe_sticky_d = pe_sticky_q;
          end
          if (fetch_fall_s) begin
            state_d = COMPUTE;
          end else begin
            state_d = FETCH;
          end
        end
        COMPUTE: begin
          if (pe_done || pe_sticky_q) begin
            state_d = WRITE;
          end else begin
            state_d = COMPUTE;
          end
        end
        WRITE: begin
          if (ofm_wr_done) begin
            state_d = NEXT;
          end else begin
            state_d = WRITE;
          end
        end
        NEXT: begin
          if (tile_q == LAST_TILE) begin
            state_d = FIN;
          end else begin
            tile_d  = tile_q + TILE_IDX_W'(1);
            state_d = LOAD;
          end
        end
        FIN: begin
          tile_d  = '0;
          state_d = IDLE;
        end
        default: begin
          tile_d      = '0;
          pe_sticky_d = 1'b0;
          state_d     = IDLE;
        end
      endcase
    end
  end

  // State, counter and registered output strobes, all decoded from next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tile_q      <= '0;
      pe_sticky_q <= 1'b0;
      load_q      <= 1'b0;
      wr_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tile_q      <= tile_d;
      pe_sticky_q <= pe_sticky_d;
      load_q      <= (state_d == LOAD);
      wr_start_q  <= (state_d == WRITE) && (state_q != WRITE);
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == FIN);
    end
  end

  assign ifm_load     = load_q;
  assign wgt_load     = load_q;
  assign ofm_wr_start = wr_start_q;
  assign tile_idx     = tile_q;
  assign busy         = busy_q;
  assign done         = done_q;

`ifdef TILE_SCHED_PERF_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;

  // Busy-cycle counter: cleared by an accepted start, saturates, holds when idle
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if (start_acc_s) begin
      cycle_cnt_d = 32'd0;
    end else if (busy_q && (cycle_cnt_q != 32'hFFFF_FFFF)) begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
    end else begin
      cycle_cnt_d = cycle_cnt_q;
    end
  end

  // Busy-cycle counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= 32'd0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign cycle_count = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// tb_conv_tile_scheduler: directed bench for conv_tile_scheduler (default
// geometry: 64 tiles). Inputs change 1 time unit after the rising edge; a
// negedge monitor counts output pulses and follows the tile sequence.
// Compile with TILE_SCHED_PERF_EN defined to also cover cycle_count.
module tb_conv_tile_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort, ifm_addr_valid, pe_done, ofm_wr_done;
  logic       ifm_load, wgt_load, ofm_wr_start, busy, done;
  logic [5:0] tile_idx;
`ifdef TILE_SCHED_PERF_EN
  logic [31:0] cycle_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int n_load  = 0;
  int n_done  = 0;
  int n_wrs   = 0;
  int n_busy  = 0;
  int exp_tile_q = 0;

  conv_tile_scheduler dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .ifm_load       (ifm_load),
    .wgt_load       (wgt_load),
    .ifm_addr_valid (ifm_addr_valid),
    .pe_done        (pe_done),
    .ofm_wr_start   (ofm_wr_start),
    .ofm_wr_done    (ofm_wr_done),
    .tile_idx       (tile_idx),
    .busy           (busy),
    .done           (done)
`ifdef TILE_SCHED_PERF_EN
    ,
    .cycle_count    (cycle_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_load(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (ifm_load) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Pulse counters and tile-sequence follower
  always @(negedge clk) begin
    if (ifm_load || wgt_load) begin
      check("load_pair", {31'd0, wgt_load}, {31'd0, ifm_load});
      check("tile_seq", {26'd0, tile_idx}, exp_tile_q);
      n_load     <= n_load + 1;
      exp_tile_q <= exp_tile_q + 1;
    end else if (!busy) begin
      exp_tile_q <= 0;
    end else begin
      exp_tile_q <= exp_tile_q;
    end
    if (done) begin
      check("mon_done_tile", {26'd0, tile_idx}, 32'd63);
      n_done <= n_done + 1;
    end
    if (ofm_wr_start) n_wrs <= n_wrs + 1;
    if (busy) n_busy <= n_busy + 1;
  end

  // One layer with optional events (-1 disables): abort in COMPUTE of tile
  // abort_at, stray start during fetch of restart_at, pe_done during fetch of
  // pe_fetch_at, wr_done with wr_start at same_wr_at, async reset in WRITE of reset_at.
  task automatic run_layer(input int abort_at, input int restart_at, input int pe_fetch_at,
                           input int same_wr_at, input int reset_at);
    int load0, done0, wrs0;
    bit ok;
    load0 = n_load;
    done0 = n_done;
    wrs0  = n_wrs;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_load", ifm_load, 32'd1);
    check("start_busy", busy, 32'd1);
    check("start_tile", tile_idx, 32'd0);
    for (int t = 0; t < 64; t++) begin
      wait_load(ok);
      if (!ok) begin
        check("load_timeout", 32'd0, 32'd1);
        return;
      end
      check("tile_idx", tile_idx, t);
      ifm_addr_valid = 1'b1;
      for (int i = 0; i < 18; i++) begin
        pe_done = (t == pe_fetch_at) && (i == 5);
        start   = (t == restart_at) && (i == 3);
        tick();
      end
      pe_done        = 1'b0;
      start          = 1'b0;
      ifm_addr_valid = 1'b0;
      tick();
      check("compute_no_wrs", ofm_wr_start, 32'd0);
      if (t == abort_at) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 32'd0);
        check("abort_tile", tile_idx, 32'd0);
        check("abort_wrs", ofm_wr_start, 32'd0);
        repeat (30) tick();
        check("abort_no_done", n_done - done0, 32'd0);
        check("abort_wrs_cnt", n_wrs - wrs0, abort_at);
        check("abort_loads", n_load - load0, abort_at + 1);
        return;
      end
      if (t != pe_fetch_at) pe_done = 1'b1;
      tick();
      pe_done = 1'b0;
      check("wr_start", ofm_wr_start, 32'd1);
      if (t == reset_at) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_outs", {ifm_load, wgt_load, ofm_wr_start, busy, done, tile_idx}, 32'd0);
`ifdef TILE_SCHED_PERF_EN
        check("rst_cycle_count", cycle_count, 32'd0);
`endif
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", busy, 32'd0);
        return;
      end
      if (t != same_wr_at) repeat (2) tick();
      ofm_wr_done = 1'b1;
      tick();
      ofm_wr_done = 1'b0;
      if (t == same_wr_at) begin
        tick();
        check("wr_same_load", ifm_load, 32'd1);
      end
    end
    tick();
    check("done_pulse", done, 32'd1);
    check("done_tile", tile_idx, 32'd63);
    tick();
    check("done_busy_low", busy, 32'd0);
    check("done_clear", done, 32'd0);
    check("idle_tile", tile_idx, 32'd0);
    repeat (3) tick();
    check("n_loads", n_load - load0, 32'd64);
    check("n_done", n_done - done0, 32'd1);
    check("n_wrs", n_wrs - wrs0, 32'd64);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    rst_n          = 1'b0;
    start          = 1'b0;
    abort          = 1'b0;
    ifm_addr_valid = 1'b0;
    pe_done        = 1'b0;
    ofm_wr_done    = 1'b0;
    #23;
    check("reset_outs", {ifm_load, wgt_load, ofm_wr_start, busy, done, tile_idx}, 32'd0);
`ifdef TILE_SCHED_PERF_EN
    check("reset_cycle_count", cycle_count, 32'd0);
`endif
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_busy", busy, 32'd0);

    // start and abort together while idle: abort wins
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", busy, 32'd0);
    check("start_abort_load", ifm_load, 32'd0);
    tick();

    // Scenario 1: plain full layer, 24 cycles per tile plus FIN
    b0 = n_busy;
    run_layer(-1, -1, -1, -1, -1);
    check("busy_cycles", n_busy - b0, 32'd1537);
`ifdef TILE_SCHED_PERF_EN
    check("perf_full", cycle_count, 32'd1537);
`endif

    // Scenario 3: abort in COMPUTE of tile 5
    b0 = n_busy;
    run_layer(5, -1, -1, -1, -1);
`ifdef TILE_SCHED_PERF_EN
    check("perf_abort", cycle_count, n_busy - b0);
`endif

    // Scenarios 2, 4, 5 combined in a full run after the abort
    run_layer(-1, 10, 3, 7, -1);

    // Scenario 6: asynchronous reset in WRITE of tile 1
    run_layer(-1, -1, -1, -1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
